// File: rtl/prbs15_checker.sv
// prbs15_checker: byte-wide PRBS-15 (x^15 + x^14 + 1) bit-error checker.
// It synchronises to the received stream on its own, counts checked bits
// and bit errors (both saturating) and reports a lock indication.
module prbs15_checker #(
    parameter int ERR_W        = 32,
    parameter int LOCK_BYTES   = 4,
    parameter int UNLOCK_BYTES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             data_valid,
    input  logic [7:0]       data_in,
    output logic             locked,
    output logic             err_byte,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] bit_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Run counters are 8 bits wide; thresholds above 255 are not supported.
    localparam logic [7:0] LOCK_TH   = 8'(LOCK_BYTES);
    localparam logic [7:0] UNLOCK_TH = 8'(UNLOCK_BYTES);

    state_t           state_q;
    logic [14:0]      hist_q;
    logic             fill_q;      // set once the first FILL byte has been taken
    logic [7:0]       good_run_q;
    logic [7:0]       bad_run_q;
    logic             locked_q;
    logic             err_byte_q;
    logic             busy_q;
    logic [ERR_W-1:0] err_count_q;
    logic [ERR_W-1:0] bit_count_q;

    logic [14:0]      hist_d;
    logic [7:0]       err_vec_s;
    logic [3:0]       err_pop_s;
    logic [ERR_W-1:0] err_base_s;
    logic [ERR_W-1:0] bit_base_s;
    logic [ERR_W+3:0] err_sum_s;
    logic [ERR_W+3:0] bit_sum_s;
    logic [ERR_W-1:0] err_count_d;
    logic [ERR_W-1:0] bit_count_d;
    logic [7:0]       good_run_d;
    logic [7:0]       bad_run_d;

    // Eight-step chain: predict each bit from the received history, flag the
    // difference, then shift the received bit in (bit 7 is earliest).
    always_comb begin
        hist_d    = hist_q;
        err_vec_s = 8'd0;
        err_pop_s = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            err_vec_s[i] = data_in[i] ^ hist_d[13] ^ hist_d[14];
            hist_d       = {hist_d[13:0], data_in[i]};
            err_pop_s    = err_pop_s + {3'd0, err_vec_s[i]};
        end
    end

    // Saturating counter and run-length next values; clear drops the old total
    // so a cleared cycle holds only the current byte's contribution.
    always_comb begin
        err_base_s = clear ? {ERR_W{1'b0}} : err_count_q;
        bit_base_s = clear ? {ERR_W{1'b0}} : bit_count_q;
        err_sum_s  = {4'd0, err_base_s} + {{ERR_W{1'b0}}, err_pop_s};
        bit_sum_s  = {4'd0, bit_base_s} + {{ERR_W{1'b0}}, 4'd8};
        if (err_sum_s[ERR_W+3:ERR_W] != 4'd0) begin
            err_count_d = {ERR_W{1'b1}};
        end else begin
            err_count_d = err_sum_s[ERR_W-1:0];
        end
        if (bit_sum_s[ERR_W+3:ERR_W] != 4'd0) begin
            bit_count_d = {ERR_W{1'b1}};
        end else begin
            bit_count_d = bit_sum_s[ERR_W-1:0];
        end
        if (good_run_q >= LOCK_TH) begin
            good_run_d = good_run_q;
        end else begin
            good_run_d = good_run_q + 8'd1;
        end
        if (bad_run_q >= UNLOCK_TH) begin
            bad_run_d = bad_run_q;
        end else begin
            bad_run_d = bad_run_q + 8'd1;
        end
    end

    // Control FSM with registered status outputs; start overrides everything
    // but reset, and the byte presented with start is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hist_q      <= 15'd0;
            fill_q      <= 1'b0;
            good_run_q  <= 8'd0;
            bad_run_q   <= 8'd0;
            locked_q    <= 1'b0;
            err_byte_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_count_q <= {ERR_W{1'b0}};
            bit_count_q <= {ERR_W{1'b0}};
        end else if (start) begin
            state_q     <= ST_FILL;
            fill_q      <= 1'b0;
            good_run_q  <= 8'd0;
            bad_run_q   <= 8'd0;
            locked_q    <= 1'b0;
            err_byte_q  <= 1'b0;
            busy_q      <= 1'b1;
            err_count_q <= {ERR_W{1'b0}};
            bit_count_q <= {ERR_W{1'b0}};
        end else begin
            err_byte_q <= 1'b0;
            if (clear) begin
                err_count_q <= {ERR_W{1'b0}};
                bit_count_q <= {ERR_W{1'b0}};
            end
            if (data_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        hist_q <= hist_q;
                    end
                    ST_FILL: begin
                        hist_q <= hist_d;
                        if (fill_q) begin
                            fill_q  <= 1'b0;
                            state_q <= ST_CHECK;
                        end else begin
                            fill_q <= 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        hist_q      <= hist_d;
                        err_count_q <= err_count_d;
                        bit_count_q <= bit_count_d;
                        err_byte_q  <= |err_vec_s;
                        if (err_vec_s == 8'd0) begin
                            good_run_q <= good_run_d;
                            bad_run_q  <= 8'd0;
                            if (good_run_d == LOCK_TH) begin
                                locked_q <= 1'b1;
                            end
                        end else begin
                            bad_run_q  <= bad_run_d;
                            good_run_q <= 8'd0;
                            if (bad_run_d == UNLOCK_TH) begin
                                locked_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign err_byte  = err_byte_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_prbs15_checker.sv
// tb_prbs15_checker: directed test of prbs15_checker with hand-computed
// expectations; a second instance with a 4-bit counter width shares inputs.
module tb_prbs15_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clear;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        locked, err_byte, busy;
    logic [31:0] err_count, bit_count;
    logic        locked4, err_byte4, busy4;
    logic [3:0]  err_count4, bit_count4;

    int total = 0;
    int bad   = 0;
    logic [14:0] gen_q;
    int pulses;
    logic p20, p22, lock_lost;
    logic [7:0] b;

    always #5 clk = ~clk;

    prbs15_checker dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .data_valid(data_valid), .data_in(data_in),
        .locked(locked), .err_byte(err_byte), .err_count(err_count),
        .bit_count(bit_count), .busy(busy)
    );

    prbs15_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .data_valid(data_valid), .data_in(data_in),
        .locked(locked4), .err_byte(err_byte4), .err_count(err_count4),
        .bit_count(bit_count4), .busy(busy4)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference PRBS-15 source: newest bit in gen_q[0], bit 7 emitted first.
    task automatic gen_byte(output logic [7:0] v);
        logic nb;
        for (int i = 7; i >= 0; i--) begin
            nb    = gen_q[13] ^ gen_q[14];
            v[i]  = nb;
            gen_q = {gen_q[13:0], nb};
        end
    endtask

    // Apply one cycle of inputs on the falling edge, sample 1 ns after rise.
    task automatic drive(input logic [7:0] d, input logic v, input logic s, input logic c);
        @(negedge clk);
        data_in    = d;
        data_valid = v;
        start      = s;
        clear      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        drive(8'h00, 1'b1, 1'b1, 1'b0);
        gen_q = 15'h7FFF;
    endtask

    task automatic clean_byte();
        logic [7:0] v;
        gen_byte(v);
        drive(v, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; data_valid = 1'b0; data_in = 8'h00;
        gen_q = 15'h7FFF;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            drive(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        check_val("rst_locked", {31'd0, locked}, 32'd0);
        check_val("rst_err_byte", {31'd0, err_byte}, 32'd0);
        check_val("rst_err_count", err_count, 32'd0);
        check_val("rst_bit_count", bit_count, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        check_val("idle_busy", {31'd0, busy}, 32'd0);
        do_start();
        check_val("start_busy", {31'd0, busy}, 32'd1);

        // Clean stream of 100 bytes
        pulses = 0;
        for (int i = 1; i <= 100; i++) begin
            clean_byte();
            if (err_byte) pulses++;
            if (i == 5) check_val("clean_lock_b5", {31'd0, locked}, 32'd0);
            if (i == 6) check_val("clean_lock_b6", {31'd0, locked}, 32'd1);
        end
        check_val("clean_err", err_count, 32'd0);
        check_val("clean_bits", bit_count, 32'd784);
        check_val("clean_pulses", pulses, 32'd0);
        check_val("clean_locked", {31'd0, locked}, 32'd1);

        // Single line error: byte 20 bit 3 inverted
        do_start();
        check_val("restart_bits", bit_count, 32'd0);
        check_val("restart_locked", {31'd0, locked}, 32'd0);
        pulses = 0; p20 = 1'b0; p22 = 1'b0; lock_lost = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            gen_byte(b);
            if (i == 20) b = b ^ 8'h08;
            drive(b, 1'b1, 1'b0, 1'b0);
            if (err_byte) begin
                pulses++;
                if (i == 20) p20 = 1'b1;
                if (i == 22) p22 = 1'b1;
            end
            if (i >= 6 && !locked) lock_lost = 1'b1;
        end
        check_val("flip_err", err_count, 32'd3);
        check_val("flip_pulses", pulses, 32'd2);
        check_val("flip_p20", {31'd0, p20}, 32'd1);
        check_val("flip_p22", {31'd0, p22}, 32'd1);
        check_val("flip_lock_lost", {31'd0, lock_lost}, 32'd0);

        // Locked, then two 0xFF bytes (8 errors, then 3 errors)
        do_start();
        for (int i = 1; i <= 6; i++) clean_byte();
        check_val("ff_pre_locked", {31'd0, locked}, 32'd1);
        drive(8'hFF, 1'b1, 1'b0, 1'b0);
        check_val("ff1_err_byte", {31'd0, err_byte}, 32'd1);
        check_val("ff1_locked", {31'd0, locked}, 32'd1);
        check_val("ff1_err", err_count, 32'd8);
        drive(8'hFF, 1'b1, 1'b0, 1'b0);
        check_val("ff2_err_byte", {31'd0, err_byte}, 32'd1);
        check_val("ff2_locked", {31'd0, locked}, 32'd0);
        check_val("ff2_err", err_count, 32'd11);
        check_val("ff2_busy", {31'd0, busy}, 32'd1);

        // Continuous 0xFF from start; 4-bit instance saturates
        do_start();
        drive(8'hFF, 1'b1, 1'b0, 1'b0);
        drive(8'hFF, 1'b1, 1'b0, 1'b0);
        check_val("allff_fill_err", err_count, 32'd0);
        check_val("allff_fill_bits", bit_count, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            drive(8'hFF, 1'b1, 1'b0, 1'b0);
            check_val("allff_err", err_count, 32'(8 * k));
            check_val("allff_locked", {31'd0, locked}, 32'd0);
            check_val("w4_err", {28'd0, err_count4}, (k == 1) ? 32'd8 : 32'd15);
            check_val("w4_bits", {28'd0, bit_count4}, (k == 1) ? 32'd8 : 32'd15);
        end

        // Mid-CHECK start with clear, then clear alone
        do_start();
        for (int i = 1; i <= 10; i++) clean_byte();
        check_val("mid_bits", bit_count, 32'd64);
        drive(8'h00, 1'b1, 1'b1, 1'b1);
        gen_q = 15'h7FFF;
        check_val("sc_bits", bit_count, 32'd0);
        check_val("sc_err", err_count, 32'd0);
        check_val("sc_locked", {31'd0, locked}, 32'd0);
        check_val("sc_busy", {31'd0, busy}, 32'd1);
        clean_byte();
        check_val("sc_fill1_bits", bit_count, 32'd0);
        clean_byte();
        check_val("sc_fill2_bits", bit_count, 32'd0);
        clean_byte();
        check_val("sc_chk1_bits", bit_count, 32'd8);
        for (int i = 1; i <= 3; i++) clean_byte();
        check_val("sc_chk4_bits", bit_count, 32'd32);
        gen_byte(b);
        drive(b, 1'b1, 1'b0, 1'b1);
        check_val("clr_bits", bit_count, 32'd8);
        check_val("clr_err", err_count, 32'd0);

        // data_valid toggled over the clean stream
        do_start();
        for (int i = 1; i <= 100; i++) begin
            clean_byte();
            drive(8'hA5, 1'b0, 1'b0, 1'b0);
            if (i == 30) check_val("dv_gap_err_byte", {31'd0, err_byte}, 32'd0);
            if (i == 30) check_val("dv_gap_bits", bit_count, 32'd224);
        end
        check_val("dv_err", err_count, 32'd0);
        check_val("dv_bits", bit_count, 32'd784);
        check_val("dv_locked", {31'd0, locked}, 32'd1);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_locked", {31'd0, locked}, 32'd0);
        check_val("arst_bits", bit_count, 32'd0);
        check_val("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs15_checker.md
# prbs15_checker

Byte-wide PRBS-15 (x^15 + x^14 + 1) bit-error checker that consumes the 8-bit stream produced by the PRBS generator stage once the pattern detector has fired. It self-synchronises to the received sequence, counts checked bits and bit errors, and reports a lock indication. It sits downstream of `prbs_out`/`pattern_found` in the FPGA top level and feeds status/debug logic.

## Interface

- `ERR_W`, 32: width of the error and bit counters.
- `LOCK_BYTES`, 4: consecutive error-free checked bytes required to assert `locked`.
- `UNLOCK_BYTES`, 2: consecutive errored checked bytes required to drop `locked`.

Ports:

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse that (re)starts checking, driven by `pattern_found`.
- `clear` input 1: zeroes the counters without changing state.
- `data_valid` input 1: `data_in` is accepted on this cycle; the top level ties it to 1.
- `data_in` input 8: received PRBS byte; bit 7 is the earliest bit in time.
- `locked` output 1: the checker is synchronised.
- `err_byte` output 1: one-cycle pulse when the last checked byte contained at least one error.
- `err_count` output ERR_W: accumulated bit errors, saturating.
- `bit_count` output ERR_W: accumulated checked bits, saturating.
- `busy` output 1: high when state is not IDLE.

## Operation

- State machine: IDLE, FILL, CHECK.
  - IDLE → FILL on `start`.
  - FILL → CHECK after 2 accepted bytes.
  - CHECK stays in CHECK until `start` or `rst`.
- `start` in any state:
  - go to FILL and clear both counters, `locked`, the good/bad run counters, the fill counter and `err_byte`;
  - the byte on the `start` cycle is not consumed.
- History register `h[14:0]`: `h[0]` is the newest received bit.
  - Each accepted byte shifts in bits 7 down to 0, in that order, as an 8-step combinational chain.
- FILL: shift the bytes into history only; no checking and no counting.
- CHECK, for each bit in order:
  - `expected = h[13] ^ h[14]`;
  - `error = data_in[i] ^ expected`;
  - then shift `data_in[i]` in.
  - The checker compares against the received history, not a local generator. It is therefore self-synchronising: one flipped line bit produces 3 error flags, at bit offsets n, n+14 and n+15.
- Per accepted CHECK byte:
  - `err_count += popcount(errors)`, range 0..8;
  - `bit_count += 8`;
  - both saturate at all-ones and never wrap.
- Lock logic, per CHECK byte:
  - error-free byte: good_run++ and bad_run=0;
  - errored byte: bad_run++ and good_run=0.
  - `locked` sets when good_run reaches LOCK_BYTES.
  - `locked` clears when bad_run reaches UNLOCK_BYTES; the state stays CHECK.
  - Run counters saturate at their thresholds.
- `clear` zeroes `err_count` and `bit_count` only.
  - `clear` together with an accepted byte: the result is that byte's contribution alone.
  - `start` has priority over `clear`.
- `data_valid` low: everything holds and `err_byte` is 0.
- Limitation: an all-zero stream satisfies the recurrence and reports no errors.

## Timing

- Reset values: `locked`=0, `err_byte`=0, `err_count`=0, `bit_count`=0, `busy`=0; state IDLE; history, fill and run counters all 0.
- All outputs are registered with 1-cycle latency: a byte accepted at edge k is reflected in the outputs after edge k.
- `busy` is high from the cycle after `start` onward.
- Throughput: one byte per clock, no back-pressure.
- `rst` asserted mid-operation forces the reset values immediately, independent of `clk`.

## Test plan

- Reset with random inputs → all outputs 0, `busy`=0; `start` → `busy`=1 on the next cycle.
- `start`, then 100 correct PRBS-15 bytes (seed 0x7FFF) → `locked` rises after byte 6 (2 fill + 4 good), `err_count`=0, `bit_count`=784, `err_byte` never pulses.
- As above, with byte 20 bit 3 inverted:
  - `err_count`=3;
  - `err_byte` pulses for bytes 20 and 22 only;
  - `locked` stays 1.
- Locked stream followed by two 0xFF bytes → `err_byte` pulses twice and `locked` drops after the second.
  - Continuous 0xFF from `start` → `err_count` rises by 8 per byte and `locked` is never set.
- Mid-CHECK `start`, with `clear` asserted on the same cycle → counters 0, `locked` 0, two FILL bytes pass uncounted.
  - `clear` alone during a clean byte → `bit_count`=8 on the next cycle.
- `data_valid` toggled 1/0 over the clean-stream test → identical final counts.
  - With `ERR_W`=4 and a 0xFF stream → `err_count` saturates at 15 and holds.
